arqui_traffic_gen: RTL

//  Synthesizable, parametrised stimulus/drain engine for the arqui FIFO/arbiter datapath.

---
 rtl/arqui_traffic_gen_if.sv | 60 ++++++
 rtl/arqui_traffic_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arqui_traffic_gen_if.sv
// ----------------------------------------------------------------------------
// arqui_traffic_gen_if
//   Bundles every non-clock/reset signal of the arqui traffic generator.
//   master : the traffic generator's view (drives push/pop/init/thresholds/status)
//   slave  : the arqui datapath / controller view (drives start, back-pressure,
//            destination empties and read data)
//   Signals:
//     start, fifo_pause_main           run request and main FIFO back-pressure
//     fifo_empty[N_DEST]               per-destination empty flags
//     data_out[N_DEST*DATA_W]          destination read data, lane i = [i*DATA_W +: DATA_W]
//     data_in, push_main               word and push strobe into the main FIFO
//     pop[N_DEST], init                per-destination pop, threshold-load strobe
//     afMF_i/aeMF_i/afVC_i/aeVC_i/afDF_i/aeDF_i   FIFO thresholds
//     busy, done, mismatch, timeout    run status
//     sent_cnt, recv_cnt, chk_ok       traffic counters and checksum result
// ----------------------------------------------------------------------------
interface arqui_traffic_gen_if #(
    parameter int DATA_W  = 6,
    parameter int N_DEST  = 2,
    parameter int CNT_W   = 8,
    parameter int MF_TH_W = 2,
    parameter int VC_TH_W = 4,
    parameter int DF_TH_W = 2
);
    logic                       start;
    logic                       fifo_pause_main;
    logic [N_DEST-1:0]          fifo_empty;
    logic [N_DEST*DATA_W-1:0]   data_out;
    logic [DATA_W-1:0]          data_in;
    logic                       push_main;
    logic [N_DEST-1:0]          pop;
    logic                       init;
    logic [MF_TH_W-1:0]         afMF_i;
    logic [MF_TH_W-1:0]         aeMF_i;
    logic [VC_TH_W-1:0]         afVC_i;
    logic [VC_TH_W-1:0]         aeVC_i;
    logic [DF_TH_W-1:0]         afDF_i;
    logic [DF_TH_W-1:0]         aeDF_i;
    logic                       busy;
    logic                       done;
    logic                       mismatch;
    logic                       timeout;
    logic [CNT_W-1:0]           sent_cnt;
    logic [CNT_W-1:0]           recv_cnt;
    logic                       chk_ok;

    modport master (
        input  start, fifo_pause_main, fifo_empty, data_out,
        output data_in, push_main, pop, init,
               afMF_i, aeMF_i, afVC_i, aeVC_i, afDF_i, aeDF_i,
               busy, done, mismatch, timeout, sent_cnt, recv_cnt, chk_ok
    );

    modport slave (
        output start, fifo_pause_main, fifo_empty, data_out,
        input  data_in, push_main, pop, init,
               afMF_i, aeMF_i, afVC_i, aeVC_i, afDF_i, aeDF_i,
               busy, done, mismatch, timeout, sent_cnt, recv_cnt, chk_ok
    );
endinterface

// File: rtl/arqui_traffic_gen.sv
// ----------------------------------------------------------------------------
// arqui_traffic_gen
//   Stimulus/drain engine for the arqui FIFO/arbiter datapath. Drives the
//   threshold ports, pulses init for CFG_CYCLES cycles, pushes NUM_WORDS
//   consecutive words (SEED, SEED+1, ...) into the main FIFO while honouring
//   back-pressure, pops every non-empty destination FIFO, and reports sent and
//   received counts plus loss (mismatch) and drain timeout.
//   Ports:
//     clk      clock, all state on posedge
//     reset_L  asynchronous active-low reset
//     bus      arqui_traffic_gen_if.master (see interface header for signals)
//   Optional feature:
//     ARQUI_TG_CHECKSUM_EN  when defined, XOR-accumulates pushed words and popped
//                           lane words; chk_ok reports their equality in DONE.
//                           When undefined no accumulators exist, chk_ok = 0.
// ----------------------------------------------------------------------------
module arqui_traffic_gen #(
    parameter int                DATA_W      = 6,
    parameter int                N_DEST      = 2,
    parameter int                NUM_WORDS   = 16,
    parameter int                CNT_W       = 8,
    parameter logic [DATA_W-1:0] SEED        = 6'b101100,
    parameter int                CFG_CYCLES  = 2,
    parameter int                MF_TH_W     = 2,
    parameter int                VC_TH_W     = 4,
    parameter int                DF_TH_W     = 2,
    parameter int                AF_MF       = 3,
    parameter int                AE_MF       = 1,
    parameter int                AF_VC       = 14,
    parameter int                AE_VC       = 2,
    parameter int                AF_DF       = 3,
    parameter int                AE_DF       = 1,
    parameter int                DRAIN_QUIET = 4,
    parameter int                DRAIN_TMO   = 64
) (
    input  logic               clk,
    input  logic               reset_L,
    arqui_traffic_gen_if.master bus
);

    localparam int CFG_W   = $clog2(CFG_CYCLES + 1);
    localparam int DRN_MAX = (DRAIN_TMO > DRAIN_QUIET) ? DRAIN_TMO : DRAIN_QUIET;
    localparam int DRN_W   = $clog2(DRN_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   data_in_r;
    logic [DATA_W-1:0]   next_word;
    logic                push_main_r;
    logic                init_r;
    logic                timeout_r;
    logic [CNT_W-1:0]    sent_cnt_r;
    logic [CNT_W-1:0]    recv_cnt_r;
    logic [CFG_W-1:0]    cfg_cnt;
    logic [DRN_W-1:0]    drain_cnt;
    logic [DRN_W-1:0]    quiet_cnt;

    logic                enter_cfg;
    logic                cfg_last;
    logic                run_last;
    logic                all_empty;
    logic                quiet_hit;
    logic                tmo_hit;
    logic                push_go;
    logic                busy_c;
    logic                done_c;
    logic                mismatch_c;
    logic                chk_ok_c;
    logic [N_DEST-1:0]   pop_c;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_DEST-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_DEST; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Unsigned add that clamps at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign enter_cfg = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
    assign cfg_last  = (cfg_cnt == CFG_W'(CFG_CYCLES - 1));
    assign run_last  = (sent_cnt_r == CNT_W'(NUM_WORDS));
    assign all_empty = &bus.fifo_empty;
    // quiet_hit fires on the DRAIN_QUIET-th consecutive all-empty cycle.
    assign quiet_hit = all_empty && (quiet_cnt == DRN_W'(DRAIN_QUIET - 1));
    assign tmo_hit   = (drain_cnt == DRN_W'(DRAIN_TMO - 1));
    assign push_go   = (state == ST_RUN) && !bus.fifo_pause_main &&
                       (sent_cnt_r < CNT_W'(NUM_WORDS));

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start)             state_nxt = ST_CONFIG;
            ST_CONFIG: if (cfg_last)              state_nxt = ST_RUN;
            ST_RUN:    if (run_last)              state_nxt = ST_DRAIN;
            ST_DRAIN:  if (quiet_hit || tmo_hit)  state_nxt = ST_DONE;
            ST_DONE:   if (bus.start)             state_nxt = ST_CONFIG;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        busy_c     = 1'b0;
        done_c     = 1'b0;
        pop_c      = '0;
        case (state)
            ST_CONFIG: busy_c = 1'b1;
            ST_RUN, ST_DRAIN: begin
                busy_c = 1'b1;
                // Popping only non-empty lanes guarantees no pop on empty.
                pop_c  = ~bus.fifo_empty;
            end
            ST_DONE:   done_c = 1'b1;
            default:   ;
        endcase
        mismatch_c = done_c && (recv_cnt_r != sent_cnt_r);
    end

    // Push/config/drain datapath
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_in_r   <= SEED;
            next_word   <= SEED;
            push_main_r <= 1'b0;
            init_r      <= 1'b0;
            timeout_r   <= 1'b0;
            sent_cnt_r  <= '0;
            recv_cnt_r  <= '0;
            cfg_cnt     <= '0;
            drain_cnt   <= '0;
            quiet_cnt   <= '0;
        end else begin
            init_r <= (state_nxt == ST_CONFIG);
            if (enter_cfg) begin
                data_in_r   <= SEED;
                next_word   <= SEED;
                push_main_r <= 1'b0;
                timeout_r   <= 1'b0;
                sent_cnt_r  <= '0;
                recv_cnt_r  <= '0;
                cfg_cnt     <= '0;
            end else begin
                push_main_r <= push_go;
                if (push_go) begin
                    data_in_r  <= next_word;
                    next_word  <= next_word + 1'b1;
                    sent_cnt_r <= sent_cnt_r + 1'b1;
                end
                recv_cnt_r <= sat_add(recv_cnt_r, popcount(pop_c));
                if (state == ST_CONFIG) begin
                    cfg_cnt <= cfg_cnt + 1'b1;
                end
                // A quiet exit on the timeout cycle wins: not a timeout.
                if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
                    timeout_r <= tmo_hit && !quiet_hit;
                end
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
                quiet_cnt <= all_empty ? (quiet_cnt + 1'b1) : '0;
            end else begin
                drain_cnt <= '0;
                quiet_cnt <= '0;
            end
        end
    end

`ifdef ARQUI_TG_CHECKSUM_EN
    logic [N_DEST-1:0]  pop_p1;
    logic [DATA_W-1:0]  push_xor;
    logic [DATA_W-1:0]  pop_xor;
    logic [DATA_W-1:0]  lane_xor;

    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < N_DEST; i++) begin
            if (pop_p1[i]) begin
                lane_xor = lane_xor ^ bus.data_out[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read data lags pop by one cycle: pop_p1 marks lanes whose data is valid now.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_p1   <= '0;
            push_xor <= '0;
            pop_xor  <= '0;
        end else begin
            pop_p1 <= pop_c;
            if (enter_cfg) begin
                push_xor <= '0;
                pop_xor  <= '0;
            end else begin
                if (push_go) begin
                    push_xor <= push_xor ^ next_word;
                end
                pop_xor <= pop_xor ^ lane_xor;
            end
        end
    end

    assign chk_ok_c = done_c && (push_xor == pop_xor);
`else
    logic unused_data_out;
    assign unused_data_out = ^bus.data_out;
    assign chk_ok_c        = 1'b0;
`endif

    assign bus.data_in   = data_in_r;
    assign bus.push_main = push_main_r;
    assign bus.pop       = pop_c;
    assign bus.init      = init_r;
    assign bus.afMF_i    = MF_TH_W'(AF_MF);
    assign bus.aeMF_i    = MF_TH_W'(AE_MF);
    assign bus.afVC_i    = VC_TH_W'(AF_VC);
    assign bus.aeVC_i    = VC_TH_W'(AE_VC);
    assign bus.afDF_i    = DF_TH_W'(AF_DF);
    assign bus.aeDF_i    = DF_TH_W'(AE_DF);
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.mismatch  = mismatch_c;
    assign bus.timeout   = timeout_r;
    assign bus.sent_cnt  = sent_cnt_r;
    assign bus.recv_cnt  = recv_cnt_r;
    assign bus.chk_ok    = chk_ok_c;

endmodule
